// File: rtl/bp_pkg.sv
// Shared types and sizing helpers for the output-buffer write-back streamer.
// Holds the FSM state encoding and the lane/group arithmetic used by the top and the lane mux.
package bp_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        FIN  = 3'd4
    } bp_state_t;

    function automatic int bp_lanes(input int bus_dw, input int psu_dw);
        return bus_dw / psu_dw;
    endfunction

    function automatic int bp_groups(input int cols, input int lanes);
        return (cols + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/bp_lane_mux.sv
// Selects one group of column words onto the output lanes, zero-padding columns past BP_COLS.
// Purely combinational; no backpressure involvement.
module bp_lane_mux #(
    parameter int BP_COLS = 15,
    parameter int PSU_DW  = 16,
    parameter int LANES   = 4,
    parameter int GROUPS  = 4,
    parameter int GW      = 2
) (
    input  logic [BP_COLS*PSU_DW-1:0] row_dat,
    input  logic [GW-1:0]             group,
    output logic [LANES*PSU_DW-1:0]   lane_dat
);

    localparam int BEAT_W = LANES * PSU_DW;
    localparam int PAD_W  = GROUPS * BEAT_W;

    logic [PAD_W-1:0] padded;

    // Zero-extending the row gives the padding lanes of the final group for free.
    always_comb begin
        padded   = PAD_W'(row_dat);
        lane_dat = padded[group*BEAT_W +: BEAT_W];
    end

endmodule

// File: rtl/bp_out_wb_stream.sv
// Streams rows of the output buffer out as AXI-Stream beats, GROUPS beats per row.
// Latency: GROUPS+1+RD_LAT cycles per row with tready high; a beat holds while tready is low.
module bp_out_wb_stream
    import bp_pkg::*;
#(
    parameter int BP_COLS          = 15,
    parameter int PSU_DW           = 16,
    parameter int BUS_DW           = 64,
    parameter int BP_OUT_BUF_DEPTH = 10,
    parameter int RD_LAT           = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          wb_sel,
    input  logic [BP_OUT_BUF_DEPTH-1:0]   base_addr,
    input  logic [BP_OUT_BUF_DEPTH:0]     num_rows,
    output logic                          busy,
    output logic                          done,
    output logic                          buf_rd_en,
    output logic                          buf_rd_sel,
    output logic [BP_OUT_BUF_DEPTH-1:0]   buf_rd_addr,
    input  logic [BP_COLS*PSU_DW-1:0]     buf_rd_data,
    output logic [BUS_DW-1:0]             m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast
);

    localparam int LANES  = bp_lanes(BUS_DW, PSU_DW);
    localparam int GROUPS = bp_groups(BP_COLS, LANES);
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    localparam logic [GW-1:0]               LAST_GRP = GW'(GROUPS - 1);
    localparam logic [GW-1:0]               GRP_ONE  = GW'(1);
    localparam logic [1:0]                  LAST_LAT = 2'(RD_LAT - 1);
    localparam logic [BP_OUT_BUF_DEPTH-1:0] ADDR_ONE = BP_OUT_BUF_DEPTH'(1);
    localparam logic [BP_OUT_BUF_DEPTH:0]   ROW_ONE  = (BP_OUT_BUF_DEPTH + 1)'(1);

    if (BUS_DW % PSU_DW != 0) begin : g_bad_dw
        $error("bp_out_wb_stream: PSU_DW must divide BUS_DW");
    end
    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
        $error("bp_out_wb_stream: RD_LAT must be 1..3");
    end

    bp_state_t                     state_q, state_d;
    logic [BP_OUT_BUF_DEPTH-1:0]   row_addr_q;
    logic [BP_OUT_BUF_DEPTH:0]     rows_left_q;
    logic                          sel_q;
    logic [GW-1:0]                 group_q;
    logic [1:0]                    lat_q;
    logic [BP_COLS*PSU_DW-1:0]     row_q;
    logic [BUS_DW-1:0]             mux_dat;

    logic grp_last, row_last;
    assign grp_last = (group_q == LAST_GRP);
    assign row_last = (rows_left_q == ROW_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_rows == '0) ? FIN : READ;
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                if (lat_q == LAST_LAT) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (m_axis_tready && grp_last) begin
                    state_d = row_last ? FIN : READ;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Job context and row datapath; rows_left is only decremented between rows, so 1 marks the last row.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_addr_q  <= '0;
            rows_left_q <= '0;
            sel_q       <= 1'b0;
            group_q     <= '0;
            lat_q       <= '0;
            row_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        row_addr_q  <= base_addr;
                        sel_q       <= wb_sel;
                        rows_left_q <= num_rows;
                    end
                end
                READ: lat_q <= '0;
                WAIT: begin
                    lat_q <= lat_q + 2'd1;
                    if (lat_q == LAST_LAT) begin
                        row_q   <= buf_rd_data;
                        group_q <= '0;
                    end
                end
                SEND: begin
                    if (m_axis_tready) begin
                        if (grp_last) begin
                            group_q <= '0;
                            if (!row_last) begin
                                rows_left_q <= rows_left_q - ROW_ONE;
                                row_addr_q  <= row_addr_q + ADDR_ONE;
                            end
                        end else begin
                            group_q <= group_q + GRP_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    bp_lane_mux #(
        .BP_COLS (BP_COLS),
        .PSU_DW  (PSU_DW),
        .LANES   (LANES),
        .GROUPS  (GROUPS),
        .GW      (GW)
    ) u_lane_mux (
        .row_dat  (row_q),
        .group    (group_q),
        .lane_dat (mux_dat)
    );

    always_comb begin
        busy          = (state_q != IDLE);
        done          = (state_q == FIN);
        buf_rd_en     = (state_q == READ);
        buf_rd_sel    = sel_q;
        buf_rd_addr   = row_addr_q;
        m_axis_tvalid = (state_q == SEND);
        m_axis_tlast  = (state_q == SEND) && grp_last && row_last;
        m_axis_tdata  = (state_q == SEND) ? mux_dat : '0;
    end

endmodule
